// File: rtl/net_resolver.sv
// net_resolver: registered multi-driver net resolver.
//
// Resolves N enabled drivers of WIDTH bits onto one shared bus each cycle and
// registers the result (1-cycle latency, no combinational input-to-output path).
// Resolution rule is selected by MODE:
//   0 = tri-state: lowest-index enabled driver wins; any enabled driver whose data
//       differs from it flags contention
//   1 = wired-OR of enabled drivers
//   2 = wired-AND of enabled drivers
//
// Optional feature macro: NET_RESOLVER_KEEPER_EN
//   defined   : undriven cycles hold the previous bus value (bus keeper)
//   undefined : undriven cycles drive 0 (MODE 0/1) or all-ones (MODE 2)
//
// Ports:
//   clk               clock, all state on rising edge
//   rst               synchronous active-high reset, highest priority
//   drv_en[N]         per-driver enable
//   drv_data[N*WIDTH] driver i at [i*WIDTH +: WIDTH]
//   clr_sticky        pulse, clears contention_sticky and contention_cnt
//   bus_q             registered resolved bus
//   bus_valid         registered, at least one driver enabled
//   contention        registered conflict flag (MODE 0 only)
//   contention_sticky set on contention, held until clr_sticky/rst
//   contention_cnt    saturating count of contention cycles
module net_resolver #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       drv_en,
  input  logic [N*WIDTH-1:0] drv_data,
  input  logic               clr_sticky,
  output logic [WIDTH-1:0]   bus_q,
  output logic               bus_valid,
  output logic               contention,
  output logic               contention_sticky,
  output logic [CNT_W-1:0]   contention_cnt
);

  // Elaboration-time parameter checks.
  if (MODE > 2) begin : g_bad_mode
    $error("net_resolver: MODE must be 0 (tri), 1 (wor) or 2 (wand)");
  end
  if (N < 2) begin : g_bad_n
    $error("net_resolver: N must be at least 2");
  end

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] first_data;
  logic             first_found;
  logic             any_en;
  logic             conflict;
  logic [WIDTH-1:0] or_acc;
  logic [WIDTH-1:0] and_acc;
  logic [WIDTH-1:0] idle_val;
  logic [WIDTH-1:0] bus_d;
  logic             valid_d;
  logic             contention_d;
  logic             sticky_d;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_d;

  // Priority pick of the lowest-index enabled driver plus OR/AND reductions.
  always_comb begin
    first_data  = '0;
    first_found = 1'b0;
    or_acc      = '0;
    and_acc     = '1;
    for (int unsigned i = 0; i < N; i++) begin
      if (drv_en[i]) begin
        or_acc  = or_acc | drv_data[i*WIDTH +: WIDTH];
        and_acc = and_acc & drv_data[i*WIDTH +: WIDTH];
        if (!first_found) begin
          first_data  = drv_data[i*WIDTH +: WIDTH];
          first_found = 1'b1;
        end
      end
    end
  end

  // Conflict: an enabled driver disagrees with the winner. Equal values are fine.
  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (drv_en[i] && (drv_data[i*WIDTH +: WIDTH] != first_data)) begin
        conflict = 1'b1;
      end
    end
  end

  assign any_en = |drv_en;

  // Value placed on the bus when nobody drives it.
  always_comb begin
`ifdef NET_RESOLVER_KEEPER_EN
    idle_val = bus_q;
`else
    if (MODE == 2) begin
      idle_val = '1;
    end else begin
      idle_val = '0;
    end
`endif
  end

  always_comb begin
    bus_d        = idle_val;
    valid_d      = any_en;
    contention_d = 1'b0;
    if (any_en) begin
      if (MODE == 1) begin
        bus_d = or_acc;
      end else if (MODE == 2) begin
        bus_d = and_acc;
      end else begin
        bus_d        = first_data;
        contention_d = conflict;
      end
    end
  end

  // Clear is applied first, so a clear coinciding with contention yields cnt = 1.
  always_comb begin
    cnt_base = clr_sticky ? '0 : contention_cnt;
    cnt_d    = cnt_base;
    sticky_d = clr_sticky ? 1'b0 : contention_sticky;
    if (contention_d) begin
      sticky_d = 1'b1;
      if (cnt_base != CntMax) begin
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q             <= '0;
      bus_valid         <= 1'b0;
      contention        <= 1'b0;
      contention_sticky <= 1'b0;
      contention_cnt    <= '0;
    end else begin
      bus_q             <= bus_d;
      bus_valid         <= valid_d;
      contention        <= contention_d;
      contention_sticky <= sticky_d;
      contention_cnt    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_net_resolver.sv
// Bench for net_resolver: four instances share one stimulus stream
// (MODE 0, MODE 1, MODE 2, MODE 0 with a 2-bit counter). A queue-based model
// predicts every output each cycle; directed literal checks pin the model.
module tb_net_resolver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  drv_en = '0;
  logic [31:0] drv_data = '0;
  logic        clr_sticky = 1'b0;

  logic [7:0] o_bus [4];
  logic       o_val [4];
  logic       o_con [4];
  logic       o_sti [4];
  logic [7:0] o_cnt [4];
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  net_resolver #(.WIDTH(8), .N(4), .MODE(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .clr_sticky(clr_sticky),
    .bus_q(o_bus[0]), .bus_valid(o_val[0]), .contention(o_con[0]),
    .contention_sticky(o_sti[0]), .contention_cnt(cnt0)
  );
  net_resolver #(.WIDTH(8), .N(4), .MODE(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .clr_sticky(clr_sticky),
    .bus_q(o_bus[1]), .bus_valid(o_val[1]), .contention(o_con[1]),
    .contention_sticky(o_sti[1]), .contention_cnt(cnt1)
  );
  net_resolver #(.WIDTH(8), .N(4), .MODE(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .clr_sticky(clr_sticky),
    .bus_q(o_bus[2]), .bus_valid(o_val[2]), .contention(o_con[2]),
    .contention_sticky(o_sti[2]), .contention_cnt(cnt2)
  );
  net_resolver #(.WIDTH(8), .N(4), .MODE(0), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .clr_sticky(clr_sticky),
    .bus_q(o_bus[3]), .bus_valid(o_val[3]), .contention(o_con[3]),
    .contention_sticky(o_sti[3]), .contention_cnt(cnt3)
  );

  always_comb begin
    o_cnt[0] = cnt0;
    o_cnt[1] = cnt1;
    o_cnt[2] = cnt2;
    o_cnt[3] = {6'b0, cnt3};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int unsigned m_mode [4] = '{0, 1, 2, 0};
  int unsigned m_max  [4] = '{255, 255, 255, 3};
  logic [7:0]  e_bus  [4];
  logic        e_val  [4];
  logic        e_con  [4];
  logic        e_sti  [4];
  int unsigned e_cnt  [4];
  bit          started = 1'b0;
  logic [7:0]  vals [$];

  always @(posedge clk) begin
    vals.delete();
    for (int i = 0; i < 4; i++) begin
      if (drv_en[i]) vals.push_back(drv_data[i*8 +: 8]);
    end
    for (int j = 0; j < 4; j++) begin
      if (rst) begin
        e_bus[j] = 8'h00; e_val[j] = 1'b0; e_con[j] = 1'b0; e_sti[j] = 1'b0; e_cnt[j] = 0;
      end else begin
        e_con[j] = 1'b0;
        e_val[j] = (vals.size() != 0);
        if (vals.size() == 0) begin
`ifndef NET_RESOLVER_KEEPER_EN
          e_bus[j] = (m_mode[j] == 2) ? 8'hFF : 8'h00;
`endif
        end else if (m_mode[j] == 1) begin
          e_bus[j] = 8'h00;
          foreach (vals[k]) e_bus[j] = e_bus[j] | vals[k];
        end else if (m_mode[j] == 2) begin
          e_bus[j] = 8'hFF;
          foreach (vals[k]) e_bus[j] = e_bus[j] & vals[k];
        end else begin
          e_bus[j] = vals[0];
          foreach (vals[k]) if (vals[k] != vals[0]) e_con[j] = 1'b1;
        end
        if (clr_sticky) begin
          e_sti[j] = 1'b0;
          e_cnt[j] = 0;
        end
        if (e_con[j]) begin
          e_sti[j] = 1'b1;
          if (e_cnt[j] < m_max[j]) e_cnt[j]++;
        end
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("model dut%0d bus_q", j), 32'(o_bus[j]), 32'(e_bus[j]));
        chk($sformatf("model dut%0d bus_valid", j), 32'(o_val[j]), 32'(e_val[j]));
        chk($sformatf("model dut%0d contention", j), 32'(o_con[j]), 32'(e_con[j]));
        chk($sformatf("model dut%0d sticky", j), 32'(o_sti[j]), 32'(e_sti[j]));
        chk($sformatf("model dut%0d cnt", j), 32'(o_cnt[j]), e_cnt[j]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [3:0] en, input logic [31:0] data, input logic clr);
    drv_en     = en;
    drv_data   = data;
    clr_sticky = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("reset bus_q", 32'(o_bus[0]), 32'h0);
    chk("reset bus_valid", 32'(o_val[0]), 32'h0);
    chk("reset contention", 32'(o_con[0]), 32'h0);
    chk("reset sticky", 32'(o_sti[0]), 32'h0);
    chk("reset cnt", 32'(o_cnt[0]), 32'h0);
    rst = 1'b0;

    step(4'b0001, {8'h00, 8'h00, 8'h00, 8'hA5}, 1'b0);
    chk("single bus_q", 32'(o_bus[0]), 32'hA5);
    chk("single valid", 32'(o_val[0]), 32'h1);
    chk("single contention", 32'(o_con[0]), 32'h0);

    step(4'b0110, {8'h00, 8'h3C, 8'h3C, 8'h00}, 1'b0);
    chk("equal bus_q", 32'(o_bus[0]), 32'h3C);
    chk("equal contention", 32'(o_con[0]), 32'h0);

    for (int n = 1; n <= 5; n++) begin
      step(4'b0110, {8'h00, 8'hC3, 8'h3C, 8'h00}, 1'b0);
      chk("conflict bus_q", 32'(o_bus[0]), 32'h3C);
      chk("conflict contention", 32'(o_con[0]), 32'h1);
      chk("sat cnt", 32'(o_cnt[3]), (n < 3) ? n : 3);
      if (n == 3) begin
        chk("conflict sticky", 32'(o_sti[0]), 32'h1);
        chk("conflict cnt", 32'(o_cnt[0]), 32'h3);
      end
    end

    step(4'b0001, {8'h00, 8'h00, 8'h00, 8'hA5}, 1'b1);
    chk("clear sticky", 32'(o_sti[0]), 32'h0);
    chk("clear cnt", 32'(o_cnt[0]), 32'h0);
    chk("clear sat cnt", 32'(o_cnt[3]), 32'h0);

    step(4'b0110, {8'h00, 8'hC3, 8'h3C, 8'h00}, 1'b1);
    chk("clear+conflict sticky", 32'(o_sti[0]), 32'h1);
    chk("clear+conflict cnt", 32'(o_cnt[0]), 32'h1);

    step(4'b1011, {8'h11, 8'hFF, 8'hF0, 8'h0F}, 1'b0);
    chk("wor bus_q", 32'(o_bus[1]), 32'hFF);
    chk("wand bus_q", 32'(o_bus[2]), 32'h00);
    chk("wor contention", 32'(o_con[1]), 32'h0);
    chk("wand contention", 32'(o_con[2]), 32'h0);
    chk("tri 1011 bus_q", 32'(o_bus[0]), 32'h0F);

    step(4'b0001, {8'h00, 8'h00, 8'h00, 8'h5A}, 1'b0);
    chk("pre-idle bus_q", 32'(o_bus[0]), 32'h5A);
    step(4'b0000, 32'hFFFF_FFFF, 1'b0);
    chk("idle valid", 32'(o_val[0]), 32'h0);
`ifdef NET_RESOLVER_KEEPER_EN
    chk("idle tri bus_q", 32'(o_bus[0]), 32'h5A);
    chk("idle wand bus_q", 32'(o_bus[2]), 32'h5A);
`else
    chk("idle tri bus_q", 32'(o_bus[0]), 32'h00);
    chk("idle wand bus_q", 32'(o_bus[2]), 32'hFF);
`endif

    step(4'b0110, {8'h00, 8'hC3, 8'h3C, 8'h00}, 1'b0);
    chk("pre-reset contention", 32'(o_con[0]), 32'h1);
    rst = 1'b1;
    step(4'b0110, {8'h00, 8'hC3, 8'h3C, 8'h00}, 1'b0);
    chk("midreset bus_q", 32'(o_bus[0]), 32'h0);
    chk("midreset contention", 32'(o_con[0]), 32'h0);
    chk("midreset sticky", 32'(o_sti[0]), 32'h0);
    chk("midreset cnt", 32'(o_cnt[0]), 32'h0);
    rst = 1'b0;
    step(4'b0001, {8'h00, 8'h00, 8'h00, 8'h77}, 1'b0);
    chk("post-reset bus_q", 32'(o_bus[0]), 32'h77);

    // Mixed traffic; small value alphabet so equal-value drivers occur often.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] d;
      for (int b = 0; b < 4; b++) d[b*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'h3C : 8'($urandom);
      step(4'($urandom), d, ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
